// File: rtl/regfile.sv
// regfile: 2**r x n-bit register file with one synchronous write port, two
// combinational read ports, a hardwired-zero register 0, optional
// write-to-read forwarding, and a saturating count of committed writes.
module regfile #(
    parameter int n      = 32,
    parameter int r      = 5,
    parameter int bypass = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [r-1:0] wa,
    input  logic [n-1:0] wd,
    input  logic [r-1:0] ra1,
    input  logic [r-1:0] ra2,
    output logic [n-1:0] rd1,
    output logic [n-1:0] rd2,
    output logic [7:0]   wcount
);

    localparam int depth = 1 << r;

    logic [n-1:0] mem_q [depth];
    logic [n-1:0] mem_d [depth];
    logic [7:0]   wcount_q;
    logic [7:0]   wcount_d;
    logic         commit;

    // Next-state for storage and write counter; writes to register 0 are dropped.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        commit   = we && (wa != '0);
        mem_d    = mem_q;
        wcount_d = wcount_q;
        if (commit) begin
            mem_d[wa] = wd;
            if (wcount_q != 8'hFF) begin
                wcount_d = wcount_q + 8'd1;
            end
        end
    end

    // State register: asynchronous clear of every word and the counter.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments; combinational blocks use blocking.
        if (rst) begin
            // NOTE: every word is cleared on reset so reads are never X after reset.
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
            wcount_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wcount_q <= wcount_d;
        end
    end

    // Combinational read ports with optional forwarding of the pending write.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != '0) begin
            rd1 = mem_q[ra1];
        end
        if (ra2 != '0) begin
            rd2 = mem_q[ra2];
        end
        // Forwarding is suppressed while rst is high so reset always reads as zero.
        if ((bypass != 0) && commit && !rst) begin
            if (wa == ra1) begin
                rd1 = wd;
            end
            if (wa == ra2) begin
                rd2 = wd;
            end
        end
    end

    assign wcount = wcount_q;

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: drives a forwarding and a non-forwarding regfile with identical
// stimulus and compares both against an array-based reference model.
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic [4:0]  wa  = '0;
    logic [31:0] wd  = '0;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
    logic [7:0]  wcount_0, wcount_1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [32];
    int          model_cnt;

    always #5 clk = ~clk;

    regfile #(.n(32), .r(5), .bypass(0)) u_dut0 (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_0), .rd2(rd2_0), .wcount(wcount_0)
    );

    regfile #(.n(32), .r(5), .bypass(1)) u_dut1 (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_1), .rd2(rd2_1), .wcount(wcount_1)
    );

    // Reference model: a plain array plus a saturating integer count.
    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
        model_cnt = 0;
    endtask

    task automatic model_commit(input logic w_en, input logic [4:0] addr, input logic [31:0] data);
        if (w_en && addr != 5'd0) begin
            model_mem[addr] = data;
            if (model_cnt < 255) model_cnt = model_cnt + 1;
        end
    endtask

    // Performs one write edge; called with clk low, returns at the next falling edge.
    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        we = 1'b1;
        wa = addr;
        wd = data;
        @(posedge clk);
        model_commit(1'b1, addr, data);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_reset();
        we = 1'b1; wa = 5'd4; wd = 32'h1234_5678; ra1 = 5'd4; ra2 = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd1_0 !== 32'h0 || rd1_1 !== 32'h0 || rd2_0 !== 32'h0 || rd2_1 !== 32'h0) begin
            failures++;
            $display("FAIL reset_rd: rd1_0=%h rd1_1=%h rd2_0=%h rd2_1=%h required 0", rd1_0, rd1_1, rd2_0, rd2_1);
        end
        checks++;
        if (wcount_0 !== 8'd0 || wcount_1 !== 8'd0) begin
            failures++;
            $display("FAIL reset_wcount: got %0d/%0d required 0", wcount_0, wcount_1);
        end
        we = 1'b0;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (rd1_0 !== 32'h0 || rd1_1 !== 32'h0 || wcount_0 !== 8'd0) begin
            failures++;
            $display("FAIL reset_no_write: rd1=%h/%h wcount=%0d required 0", rd1_0, rd1_1, wcount_0);
        end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        do_write(5'd3, 32'h0000_0001);
        ra1 = 5'd3; ra2 = 5'd3;
        #1;
        checks++;
        if (rd1_0 !== 32'h1 || rd2_0 !== 32'h1 || rd1_1 !== 32'h1 || rd2_1 !== 32'h1) begin
            failures++;
            $display("FAIL write_read: rd=%h %h %h %h required 00000001", rd1_0, rd2_0, rd1_1, rd2_1);
        end
        checks++;
        if (wcount_0 !== 8'(model_cnt) || wcount_1 !== 8'(model_cnt)) begin
            failures++;
            $display("FAIL write_read_wcount: got %0d/%0d required %0d", wcount_0, wcount_1, model_cnt);
        end
    endtask

    task automatic test_zero_reg();
        do_write(5'd0, 32'hFFFF_FFFF);
        ra1 = 5'd0; ra2 = 5'd0;
        #1;
        checks++;
        if (rd1_0 !== 32'h0 || rd2_0 !== 32'h0 || rd1_1 !== 32'h0 || rd2_1 !== 32'h0) begin
            failures++;
            $display("FAIL zero_reg_read: rd=%h %h %h %h required 0", rd1_0, rd2_0, rd1_1, rd2_1);
        end
        checks++;
        if (wcount_0 !== 8'(model_cnt) || wcount_1 !== 8'(model_cnt)) begin
            failures++;
            $display("FAIL zero_reg_wcount: got %0d/%0d required %0d", wcount_0, wcount_1, model_cnt);
        end
        // Pending write to register 0 must not be forwarded either.
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (rd1_1 !== 32'h0 || rd1_0 !== 32'h0) begin
            failures++;
            $display("FAIL zero_reg_bypass: rd1=%h/%h required 0", rd1_0, rd1_1);
        end
        @(posedge clk);
        model_commit(we, wa, wd);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_bypass();
        do_write(5'd7, 32'h0000_0010);
        we = 1'b1; wa = 5'd7; wd = 32'h0000_0020; ra1 = 5'd7; ra2 = 5'd3;
        #1;
        checks++;
        if (rd1_1 !== 32'h0000_0020) begin
            failures++;
            $display("FAIL bypass1_before: rd1=%h required 00000020", rd1_1);
        end
        checks++;
        if (rd1_0 !== 32'h0000_0010) begin
            failures++;
            $display("FAIL bypass0_before: rd1=%h required 00000010", rd1_0);
        end
        checks++;
        if (rd2_1 !== model_mem[3] || rd2_0 !== model_mem[3]) begin
            failures++;
            $display("FAIL bypass_other_port: rd2=%h/%h required %h", rd2_0, rd2_1, model_mem[3]);
        end
        ra2 = 5'd7;
        #1;
        checks++;
        if (rd1_1 !== 32'h20 || rd2_1 !== 32'h20 || rd2_0 !== 32'h10) begin
            failures++;
            $display("FAIL bypass_both_ports: rd1_1=%h rd2_1=%h rd2_0=%h required 20 20 10", rd1_1, rd2_1, rd2_0);
        end
        @(posedge clk);
        model_commit(we, wa, wd);
        #1;
        checks++;
        if (rd1_0 !== 32'h20 || rd1_1 !== 32'h20) begin
            failures++;
            $display("FAIL bypass_after: rd1=%h/%h required 00000020", rd1_0, rd1_1);
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_hold();
        do_write(5'd9, 32'h1357_9BDF);
        we = 1'b0; wa = 5'd9; wd = 32'hAAAA_5555; ra1 = 5'd9; ra2 = 5'd9;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd1_0 !== model_mem[9] || rd2_1 !== model_mem[9]) begin
            failures++;
            $display("FAIL hold_data: rd=%h/%h required %h", rd1_0, rd2_1, model_mem[9]);
        end
        checks++;
        if (wcount_0 !== 8'(model_cnt) || wcount_1 !== 8'(model_cnt)) begin
            failures++;
            $display("FAIL hold_wcount: got %0d/%0d required %0d", wcount_0, wcount_1, model_cnt);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp0_1, exp0_2, exp1_1, exp1_2;
        for (int it = 0; it < 300; it++) begin
            we  = ($urandom_range(0, 3) != 0);
            wa  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            #1;
            exp0_1 = model_mem[ra1];
            exp0_2 = model_mem[ra2];
            exp1_1 = (we && wa != 5'd0 && wa == ra1) ? wd : exp0_1;
            exp1_2 = (we && wa != 5'd0 && wa == ra2) ? wd : exp0_2;
            checks++;
            if (rd1_0 !== exp0_1 || rd2_0 !== exp0_2 || rd1_1 !== exp1_1 || rd2_1 !== exp1_2) begin
                failures++;
                $display("FAIL random_read[%0d]: got %h %h %h %h required %h %h %h %h",
                         it, rd1_0, rd2_0, rd1_1, rd2_1, exp0_1, exp0_2, exp1_1, exp1_2);
            end
            @(posedge clk);
            model_commit(we, wa, wd);
            #1;
            checks++;
            if (wcount_0 !== 8'(model_cnt) || wcount_1 !== 8'(model_cnt)) begin
                failures++;
                $display("FAIL random_wcount[%0d]: got %0d/%0d required %0d", it, wcount_0, wcount_1, model_cnt);
            end
            @(negedge clk);
        end
        we = 1'b0;
    endtask

    task automatic test_reset_midop();
        do_write(5'd5, 32'hDEAD_BEEF);
        ra1 = 5'd5;
        #1;
        checks++;
        if (rd1_0 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL midreset_pre: rd1=%h required deadbeef", rd1_0);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (rd1_0 !== 32'h0 || rd1_1 !== 32'h0 || wcount_0 !== 8'd0 || wcount_1 !== 8'd0) begin
            failures++;
            $display("FAIL midreset_clear: rd1=%h/%h wcount=%0d/%0d required 0", rd1_0, rd1_1, wcount_0, wcount_1);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_saturation_sweep();
        for (int rep = 0; rep < 9; rep++) begin
            for (int i = 1; i < 32; i++) begin
                do_write(5'(i), 32'(i));
            end
        end
        checks++;
        if (wcount_0 !== 8'd255 || wcount_1 !== 8'd255 || model_cnt != 255) begin
            failures++;
            $display("FAIL saturation: wcount=%0d/%0d model=%0d required 255", wcount_0, wcount_1, model_cnt);
        end
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #1;
            checks++;
            if (rd1_0 !== 32'(i) || rd1_1 !== 32'(i) || rd2_0 !== 32'(31 - i) || rd2_1 !== 32'(31 - i)) begin
                failures++;
                $display("FAIL sweep[%0d]: rd1=%h/%h rd2=%h/%h required %h %h",
                         i, rd1_0, rd1_1, rd2_0, rd2_1, 32'(i), 32'(31 - i));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_hold();
        test_random();
        test_reset_midop();
        test_saturation_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, required completion");
        $fatal(1, "timeout");
    end

endmodule
